spi_rx: RTL and testbench

SPI_RX -- requirements
Module: spi_rx

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync.sv | 33 +++
 rtl/spi_rx.sv | 126 ++++++++++++
 tb/tb_spi_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame FSM state encoding and default frame width.
// Used by both the receiver and the transmitter.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        WAIT_CS = 2'd3
    } spi_state_t;

    localparam int SPI_DATA_W_DEF = 8;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a parameterised reset value, plus a registered rising-edge strobe.
// Latency: q lags d by 2 clk; rise pulses 3 clk after d rises. No backpressure.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise   <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_rx.sv
// SPI receiver, mode-0 style; LSB first unless SPI_RX_MSB_FIRST_EN is defined (then MSB first).
// Latency: rx_valid 4 clk after the clk edge that samples the last sclk rise.
// Backpressure: none; rx_valid/frame_err are single-cycle strobes the consumer must take.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              di,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sync_sclk;
    logic sclk_rise;
    logic sync_cs;
    logic cs_rise;
    logic sync_di;
    logic di_rise;
    logic unused_rise;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .q    (sync_sclk),
        .rise (sclk_rise)
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cs),
        .q    (sync_cs),
        .rise (cs_rise)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_di (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (di),
        .q    (sync_di),
        .rise (di_rise)
    );

    // The level sync of sclk is not needed once its edge strobe exists.
    assign unused_rise = cs_rise ^ di_rise ^ sync_sclk;

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_d;
    logic              frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                shreg_d = '0;
                if (!sync_cs) state_d = SHIFT;
            end
            SHIFT: begin
                // cs deassertion takes priority over a coincident sclk edge.
                if (sync_cs) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    shreg_d     = '0;
                end else if (sclk_rise) begin
`ifdef SPI_RX_MSB_FIRST_EN
                    shreg_d = {shreg_q[DATA_W-2:0], sync_di};
`else
                    shreg_d = {sync_di, shreg_q[DATA_W-1:1]};
`endif
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
                end
            end
            DONE: begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
                state_d    = WAIT_CS;
            end
            WAIT_CS: begin
                if (sync_cs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_busy = (state_q == SHIFT) || (state_q == WAIT_CS);

endmodule

// File: tb/tb_spi_rx.sv
// Directed self-checking bench for spi_rx with sclk = clk/4; inputs driven on clk falling edges.
module tb_spi_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs;
    logic       di;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_rx #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs       (cs),
        .di       (di),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    int checks = 0;
    int passes = 0;
    int val_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [7:0] caps[$];

    always @(posedge clk) begin
        if (rx_valid) begin
            val_cnt++;
            caps.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_bit(input logic b);
        di = b;
        wait_neg(2);
        sclk = 1'b1;
        wait_neg(2);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
            sclk_bit(w[7-i]);
`else
            sclk_bit(w[i]);
`endif
        end
    endtask

    task automatic cs_start();
        cs = 1'b0;
        wait_neg(2);
    endtask

    task automatic cs_end();
        wait_neg(2);
        cs = 1'b1;
        wait_neg(8);
    endtask

    initial begin
        logic [7:0] seq;
        int base_v;
        int base_e;

        rst_n = 1'b0;
        sclk  = 1'b0;
        cs    = 1'b1;
        di    = 1'b0;
        wait_neg(3);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_busy", int'(rx_busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        wait_neg(4);
        check("idle_busy", int'(rx_busy), 0);

        // Raw bit sequence sent from seq[7] down to seq[0]; both orders assemble 8'hB1.
`ifdef SPI_RX_MSB_FIRST_EN
        seq = 8'b1011_0001;
`else
        seq = 8'b1000_1101;
`endif
        base_v = val_cnt;
        base_e = err_cnt;
        cs_start();
        for (int i = 0; i < 7; i++) sclk_bit(seq[7-i]);
        check("busy_in_frame", int'(rx_busy), 1);
        di = seq[0];
        wait_neg(2);
        sclk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("lat_valid", int'(rx_valid), int'(k == 4));
            if (k == 3) check("lat_data_old", int'(rx_data), 0);
            if (k == 4) check("frame_b1", int'(rx_data), 'hB1);
        end
        @(negedge clk);
        sclk = 1'b0;
        cs_end();
        check("b1_valid_cnt", val_cnt - base_v, 1);
        check("b1_err_cnt", err_cnt - base_e, 0);
        check("b1_busy_after", int'(rx_busy), 0);

        // Short frame: cs rises after 5 bits.
        base_v = val_cnt;
        base_e = err_cnt;
        cs_start();
        for (int i = 0; i < 5; i++) sclk_bit(1'b1);
        wait_neg(1);
        cs = 1'b1;
        wait_neg(8);
        check("short_err_cnt", err_cnt - base_e, 1);
        check("short_valid_cnt", val_cnt - base_v, 0);
        check("short_data_kept", int'(rx_data), 'hB1);
        check("short_busy", int'(rx_busy), 0);

        // Ten sclk edges in one window: only the first eight count.
        base_v = val_cnt;
        base_e = err_cnt;
        cs_start();
        send_word(8'h5A);
        sclk_bit(1'b1);
        sclk_bit(1'b1);
        cs_end();
        check("over_valid_cnt", val_cnt - base_v, 1);
        check("over_err_cnt", err_cnt - base_e, 0);
        check("over_data", int'(rx_data), 'h5A);

        // Back-to-back frames with cs high for 2 clk.
        base_v = val_cnt;
        base_e = err_cnt;
        cs_start();
        send_word(8'h3C);
        wait_neg(2);
        cs = 1'b1;
        wait_neg(2);
        cs = 1'b0;
        wait_neg(2);
        send_word(8'hC3);
        cs_end();
        check("b2b_valid_cnt", val_cnt - base_v, 2);
        check("b2b_err_cnt", err_cnt - base_e, 0);
        check("b2b_first", int'(caps[caps.size()-2]), 'h3C);
        check("b2b_second", int'(caps[caps.size()-1]), 'hC3);

        // Reset in the middle of a frame.
        base_v = val_cnt;
        base_e = err_cnt;
        cs_start();
        for (int i = 0; i < 4; i++) sclk_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", int'(rx_data), 0);
        check("mid_rst_valid", int'(rx_valid), 0);
        check("mid_rst_busy", int'(rx_busy), 0);
        check("mid_rst_err", int'(frame_err), 0);
        cs = 1'b1;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(6);
        check("rel_valid_cnt", val_cnt - base_v, 0);
        check("rel_err_cnt", err_cnt - base_e, 0);
        check("rel_busy", int'(rx_busy), 0);
        cs_start();
        send_word(8'hA5);
        cs_end();
        check("post_rst_data", int'(rx_data), 'hA5);
        check("post_rst_valid_cnt", val_cnt - base_v, 1);
        check("post_rst_err_cnt", err_cnt - base_e, 0);

        check("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
